pc_sequencer: RTL

- Multi-cycle next-PC controller between EXU and IFU.
- Accepts one resolved instruction from EXU per handshake and applies the 3-bit branch-control encoding to choose the next PC. Source is PC-relative, register-relative, or trap vector/return.
- Registers the target and issues it to IFU with a valid/ready handshake.
- Sequences ecall/mret, including a one-cycle trap pulse to the CSR file, and keeps a taken-redirect counter.

---
 rtl/pc_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Next-PC controller: takes one resolved EXU result, computes the next fetch PC and trap control, and issues the PC to the IFU.
// Latency: the target is valid 2 cycles after the EXU handshake (WAIT -> CALC -> ISSUE); an ecall pulses trap_req in CALC.
// Backpressure: exu_ready is high only in WAIT; ifu_valid and ifu_pc hold steady until ifu_ready, and no new EXU result is taken until then.
module pc_sequencer #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000,
  parameter int              CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exu_valid,
  output logic              exu_ready,
  input  logic [ADDR_W-1:0] exu_pc,
  input  logic [ADDR_W-1:0] exu_imm,
  input  logic [ADDR_W-1:0] exu_rs1,
  input  logic [2:0]        branch,
  input  logic              zero,
  input  logic              less,
  input  logic              is_mret,
  input  logic [ADDR_W-1:0] csr_mtvec,
  input  logic [ADDR_W-1:0] csr_mepc,
  output logic              trap_req,
  output logic [ADDR_W-1:0] trap_epc,
  output logic              ifu_valid,
  input  logic              ifu_ready,
  output logic [ADDR_W-1:0] ifu_pc,
  output logic [CNT_W-1:0]  taken_cnt
);

  typedef enum logic [1:0] {BOOT, WAIT, CALC, ISSUE} state_t;

  // EXU result as it was seen at the handshake.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] imm;
    logic [ADDR_W-1:0] rs1;
    logic [2:0]        branch;
    logic              zero;
    logic              less;
    logic              is_mret;
  } exu_t;

  state_t            state, state_nxt;
  exu_t              cap;
  logic              nonseq;
  logic [ADDR_W-1:0] target;
  logic              target_ns;
  logic              taken;
  logic              ifu_valid_nxt;
  logic              exu_ready_nxt;
  logic              exu_hs;
  logic              ifu_hs;

  assign exu_hs = exu_valid & exu_ready;
  assign ifu_hs = ifu_valid & ifu_ready;

  // Decode the captured branch code into a target and whether it leaves the pc+4 path.
  always_comb begin
    target    = cap.pc + ADDR_W'(4);
    target_ns = 1'b0;
    taken     = 1'b0;
    case (cap.branch)
      3'b000: begin
        target_ns = 1'b0;
      end
      3'b001: begin
        target    = cap.pc + cap.imm;
        target_ns = 1'b1;
      end
      3'b010: begin
        target    = (cap.rs1 + cap.imm) & {{(ADDR_W-1){1'b1}}, 1'b0};
        target_ns = 1'b1;
      end
      3'b011: begin
        // CSR values are read here, one cycle after the handshake.
        target    = cap.is_mret ? csr_mepc : csr_mtvec;
        target_ns = 1'b1;
      end
      default: begin
        case (cap.branch[1:0])
          2'b00:   taken = cap.zero;
          2'b01:   taken = ~cap.zero;
          2'b10:   taken = cap.less;
          default: taken = ~cap.less;
        endcase
        if (taken) begin
          target    = cap.pc + cap.imm;
          target_ns = 1'b1;
        end
      end
    endcase
  end

  // Next state plus the registered handshake outputs derived from it.
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    if (ifu_hs) state_nxt = WAIT;
      WAIT:    if (exu_hs) state_nxt = CALC;
      CALC:    state_nxt = ISSUE;
      ISSUE:   if (ifu_hs) state_nxt = WAIT;
      default: state_nxt = BOOT;
    endcase
    ifu_valid_nxt = (state_nxt == BOOT) || (state_nxt == ISSUE);
    exu_ready_nxt = (state_nxt == WAIT);
  end

  // State register; valid/ready are registered so both read 0 while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      ifu_valid <= 1'b0;
      exu_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      ifu_valid <= ifu_valid_nxt;
      exu_ready <= exu_ready_nxt;
    end
  end

  // Capture the EXU result on handshake; an ecall raises trap_req for the following (CALC) cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap      <= '0;
      trap_req <= 1'b0;
      trap_epc <= '0;
    end else begin
      trap_req <= exu_hs && (branch == 3'b011) && !is_mret;
      if (exu_hs) begin
        cap <= '{pc: exu_pc, imm: exu_imm, rs1: exu_rs1, branch: branch,
                 zero: zero, less: less, is_mret: is_mret};
        if ((branch == 3'b011) && !is_mret) trap_epc <= exu_pc;
      end
    end
  end

  // Register the computed target in CALC; it stays put through ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifu_pc <= RESET_PC;
      nonseq <= 1'b0;
    end else if (state == CALC) begin
      ifu_pc <= target;
      nonseq <= target_ns;
    end
  end

  // Count redirects when the IFU actually accepts a non-pc+4 target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt <= '0;
    end else if ((state == ISSUE) && ifu_hs && nonseq) begin
      taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule
